// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: a 12-state FSM that sequences fetch, decode,
// execute, memory and write-back, decoding datapath controls from the current state.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       zero,
    output logic [2:0] ALUOp,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IorD,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ext_mode,
    output logic [1:0] PCSource,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_SUBI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC_R  = 4'd6,
        S_R_WB    = 4'd7,
        S_EXEC_I  = 4'd8,
        S_I_WB    = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;

    logic pc_write_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c;
    logic retire_c, illegal_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= 6'h00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                // The live opcode drives this one decision; later states use op_q.
                op_d = opcode;
                case (opcode)
                    OP_LW, OP_SW:                       state_d = S_MEMADDR;
                    OP_R:                               state_d = S_EXEC_R;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI,
                    OP_SUBI, OP_LUI:                    state_d = S_EXEC_I;
                    OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
                    OP_J:                               state_d = S_JUMP;
                    default:                            state_d = S_FETCH;
                endcase
            end
            S_MEMADDR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_EXEC_R:  state_d = S_R_WB;
            S_R_WB:    state_d = S_FETCH;
            S_EXEC_I:  state_d = S_I_WB;
            S_I_WB:    state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ALUOp       = 3'b000;
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        IorD        = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ext_mode    = 2'b00;
        PCSource    = 2'b00;
        retire_c    = 1'b0;
        illegal_c   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_c = 1'b1;
                ALUSrcB    = 2'b01;
                ALUOp      = 3'b010;
                pc_write_c = mem_ready;
                ir_write_c = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = 3'b010;
                case (opcode)
                    OP_LW, OP_SW, OP_R, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI,
                    OP_SUBI, OP_LUI, OP_BEQ, OP_BNE, OP_J: illegal_c = 1'b0;
                    default:                               illegal_c = 1'b1;
                endcase
            end
            S_MEMADDR: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ALUOp   = 3'b010;
            end
            S_MEMRD: begin
                mem_read_c = 1'b1;
                IorD       = 1'b1;
            end
            S_MEMWB: begin
                reg_write_c = 1'b1;
                MemtoReg    = 1'b1;
                retire_c    = 1'b1;
            end
            S_MEMWR: begin
                mem_write_c = 1'b1;
                IorD        = 1'b1;
                retire_c    = mem_ready;
            end
            S_EXEC_R: ALUSrcA = 2'b01;
            S_R_WB: begin
                reg_write_c = 1'b1;
                RegDst      = 1'b1;
                retire_c    = 1'b1;
            end
            S_EXEC_I: begin
                ALUSrcB  = 2'b10;
                ALUSrcA  = (op_q == OP_LUI) ? 2'b10 : 2'b01;
                ext_mode = (op_q == OP_LUI) ? 2'b10 :
                           ((op_q == OP_ANDI) || (op_q == OP_ORI)) ? 2'b01 : 2'b00;
                case (op_q)
                    OP_ADDI: ALUOp = 3'b011;
                    OP_ANDI: ALUOp = 3'b100;
                    OP_ORI:  ALUOp = 3'b101;
                    OP_SUBI: ALUOp = 3'b110;
                    OP_SLTI: ALUOp = 3'b111;
                    OP_LUI:  ALUOp = 3'b010;
                    default: ALUOp = 3'b000;
                endcase
            end
            S_I_WB: begin
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b01;
                ALUOp      = 3'b001;
                PCSource   = 2'b01;
                pc_write_c = ((op_q == OP_BEQ) && zero) || ((op_q == OP_BNE) && !zero);
                retire_c   = 1'b1;
            end
            S_JUMP: begin
                PCSource   = 2'b10;
                pc_write_c = 1'b1;
                retire_c   = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are masked by rst_n so a reset kills writes without waiting for a clock.
    assign PCWrite  = rst_n & pc_write_c;
    assign IRWrite  = rst_n & ir_write_c;
    assign MemRead  = rst_n & mem_read_c;
    assign MemWrite = rst_n & mem_write_c;
    assign RegWrite = rst_n & reg_write_c;
    assign retire   = rst_n & retire_c;
    assign illegal  = rst_n & illegal_c;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control: per-cycle vectors of inputs
// with hand-computed state and control word, plus a reset-during-store sequence.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       zero;
    logic [2:0] ALUOp;
    logic       PCWrite, IRWrite, MemRead, MemWrite, RegWrite;
    logic       IorD, RegDst, MemtoReg;
    logic [1:0] ALUSrcA, ALUSrcB, ext_mode, PCSource;
    logic       retire, illegal;
    logic [3:0] state;

    multicycle_control dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .opcode   (opcode),
        .mem_ready(mem_ready),
        .zero     (zero),
        .ALUOp    (ALUOp),
        .PCWrite  (PCWrite),
        .IRWrite  (IRWrite),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .RegWrite (RegWrite),
        .IorD     (IorD),
        .RegDst   (RegDst),
        .MemtoReg (MemtoReg),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ext_mode (ext_mode),
        .PCSource (PCSource),
        .retire   (retire),
        .illegal  (illegal),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: {ALUOp, PCW, IRW, MemRead, MemWrite, RegWrite, IorD, RegDst,
    // MemtoReg, ALUSrcA, ALUSrcB, ext_mode, PCSource, retire, illegal}
    logic [20:0] act_cw;
    assign act_cw = {ALUOp, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, IorD, RegDst,
                     MemtoReg, ALUSrcA, ALUSrcB, ext_mode, PCSource, retire, illegal};

    function automatic logic [20:0] cw(input logic [2:0] aluop, input logic [4:0] en,
                                       input logic [2:0] mux, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] em,
                                       input logic [1:0] ps, input logic rt, input logic il);
        return {aluop, en, mux, sa, sb, em, ps, rt, il};
    endfunction

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic        z;
        logic [3:0]  st;
        logic [20:0] c;
    } vec_t;

    vec_t vecs[80];
    int   nv;
    int   n_total;
    int   n_pass;

    logic [20:0] C_F, C_FW, C_DEC, C_DILL, C_MA, C_MRD, C_MWB, C_MWR, C_MWRW;
    logic [20:0] C_ER, C_RWB, C_ADDI, C_ANDI, C_LUI, C_SLTI, C_IWB, C_BRT, C_BRN, C_J;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic add(input logic [5:0] op, input logic mr, input logic z,
                       input logic [3:0] st, input logic [20:0] c);
        vecs[nv].op = op;
        vecs[nv].mr = mr;
        vecs[nv].z  = z;
        vecs[nv].st = st;
        vecs[nv].c  = c;
        nv++;
    endtask

    // Drive at the falling edge, check 1 ns later, then wait out the rising edge.
    task automatic step(input logic [5:0] op, input logic mr, input logic z,
                        input logic [3:0] st, input logic [20:0] c, input string nm);
        opcode    = op;
        mem_ready = mr;
        zero      = z;
        #1;
        chk({nm, " state"}, {28'd0, state}, {28'd0, st});
        chk({nm, " ctl"}, {11'd0, act_cw}, {11'd0, c});
        @(negedge clk);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        nv      = 0;
        C_F    = cw(3'b010, 5'b11100, 3'b000, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
        C_FW   = cw(3'b010, 5'b00100, 3'b000, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
        C_DEC  = cw(3'b010, 5'b00000, 3'b000, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
        C_DILL = cw(3'b010, 5'b00000, 3'b000, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1);
        C_MA   = cw(3'b010, 5'b00000, 3'b000, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
        C_MRD  = cw(3'b000, 5'b00100, 3'b100, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        C_MWB  = cw(3'b000, 5'b00001, 3'b001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        C_MWR  = cw(3'b000, 5'b00010, 3'b100, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        C_MWRW = cw(3'b000, 5'b00010, 3'b100, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        C_ER   = cw(3'b000, 5'b00000, 3'b000, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        C_RWB  = cw(3'b000, 5'b00001, 3'b010, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        C_ADDI = cw(3'b011, 5'b00000, 3'b000, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
        C_ANDI = cw(3'b100, 5'b00000, 3'b000, 2'b01, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0);
        C_LUI  = cw(3'b010, 5'b00000, 3'b000, 2'b10, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0);
        C_SLTI = cw(3'b111, 5'b00000, 3'b000, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
        C_IWB  = cw(3'b000, 5'b00001, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        C_BRT  = cw(3'b001, 5'b10000, 3'b000, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
        C_BRN  = cw(3'b001, 5'b00000, 3'b000, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
        C_J    = cw(3'b000, 5'b10000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0);

        // ADDI; opcode input changes after DECODE to expose use of the live opcode
        add(6'h08, 1, 0, 0, C_F);   add(6'h08, 1, 0, 1, C_DEC);
        add(6'h3F, 1, 0, 8, C_ADDI); add(6'h3F, 1, 0, 9, C_IWB);
        // LW with two low mem_ready cycles in MEMRD
        add(6'h23, 1, 0, 0, C_F);   add(6'h23, 1, 0, 1, C_DEC);
        add(6'h00, 1, 0, 2, C_MA);  add(6'h00, 0, 0, 3, C_MRD);
        add(6'h00, 0, 0, 3, C_MRD); add(6'h00, 1, 0, 3, C_MRD);
        add(6'h00, 1, 0, 4, C_MWB);
        // Branches: BEQ/BNE against both zero values
        add(6'h04, 1, 1, 0, C_F);   add(6'h04, 1, 1, 1, C_DEC);  add(6'h05, 1, 1, 10, C_BRT);
        add(6'h05, 1, 1, 0, C_F);   add(6'h05, 1, 1, 1, C_DEC);  add(6'h04, 1, 1, 10, C_BRN);
        add(6'h05, 1, 0, 0, C_F);   add(6'h05, 1, 0, 1, C_DEC);  add(6'h04, 1, 0, 10, C_BRT);
        add(6'h04, 1, 0, 0, C_F);   add(6'h04, 1, 0, 1, C_DEC);  add(6'h05, 1, 0, 10, C_BRN);
        // Other I-types
        add(6'h0C, 1, 0, 0, C_F);   add(6'h0C, 1, 0, 1, C_DEC);
        add(6'h0D, 1, 0, 8, C_ANDI); add(6'h0D, 1, 0, 9, C_IWB);
        add(6'h0F, 1, 0, 0, C_F);   add(6'h0F, 1, 0, 1, C_DEC);
        add(6'h08, 1, 0, 8, C_LUI); add(6'h08, 1, 0, 9, C_IWB);
        add(6'h0A, 1, 0, 0, C_F);   add(6'h0A, 1, 0, 1, C_DEC);
        add(6'h0C, 1, 0, 8, C_SLTI); add(6'h0C, 1, 0, 9, C_IWB);
        // Illegal opcode, then FETCH stalling one cycle on mem_ready
        add(6'h3F, 1, 0, 0, C_F);   add(6'h3F, 1, 0, 1, C_DILL);
        add(6'h3F, 0, 0, 0, C_FW);
        // Back-to-back R, SW, J: retire in cycles 4, 8, 11
        add(6'h00, 1, 0, 0, C_F);   add(6'h00, 1, 0, 1, C_DEC);
        add(6'h2B, 1, 0, 6, C_ER);  add(6'h2B, 1, 0, 7, C_RWB);
        add(6'h2B, 1, 0, 0, C_F);   add(6'h2B, 1, 0, 1, C_DEC);
        add(6'h00, 1, 0, 2, C_MA);  add(6'h00, 1, 0, 5, C_MWR);
        add(6'h02, 1, 0, 0, C_F);   add(6'h02, 1, 0, 1, C_DEC);
        add(6'h00, 1, 0, 11, C_J);

        // Reset: enables stay low even with mem_ready high in FETCH
        rst_n     = 1'b0;
        opcode    = 6'h00;
        mem_ready = 1'b1;
        zero      = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset state", {28'd0, state}, 32'd0);
        chk("reset enables", {25'd0, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, retire, illegal},
            32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < nv; i++)
            step(vecs[i].op, vecs[i].mr, vecs[i].z, vecs[i].st, vecs[i].c, $sformatf("row%0d", i));

        // SW held in MEMWR, then reset mid-cycle with no clock edge in between
        step(6'h2B, 1, 0, 0, C_F,    "sw_rst fetch");
        step(6'h2B, 1, 0, 1, C_DEC,  "sw_rst decode");
        step(6'h00, 1, 0, 2, C_MA,   "sw_rst memaddr");
        step(6'h00, 0, 0, 5, C_MWRW, "sw_rst memwr wait");
        #1;
        chk("sw_rst memwr held", {27'd0, state, MemWrite}, {27'd0, 4'd5, 1'b1});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst memwrite", {31'd0, MemWrite}, 32'd0);
        chk("async rst state", {28'd0, state}, 32'd0);
        chk("async rst enables", {25'd0, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, retire, illegal},
            32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(6'h00, 0, 0, 0, C_FW, "post_rst fetch0");
        step(6'h00, 0, 0, 0, C_FW, "post_rst fetch1");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 opcode  in  6  instruction[31:26] from the instruction register.
REQ-004 mem_ready  in  1  memory completion handshake; the access completes in the cycle it is high.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 ALUOp  out  3  operation class to ALU decode: 000 R-type, 001 branch, 010 add (LW/SW/LUI/PC), 011 ADDI, 100 ANDI, 101 ORI, 110 SUBI, 111 SLTI.
REQ-007 PCWrite, IRWrite, MemRead, MemWrite, RegWrite  out  1 each  write and read enables.
REQ-008 IorD, RegDst, MemtoReg  out  1 each  datapath muxes (1 = data address, rd, memory data).
REQ-009 ALUSrcA  out  2  00 PC, 01 reg A, 10 zero.
REQ-010 ALUSrcB  out  2  00 reg B, 01 constant 4, 10 extended imm, 11 sign-ext imm<<2.
REQ-011 ext_mode  out  2  00 sign-extend, 01 zero-extend, 10 imm<<16.
REQ-012 PCSource  out  2  00 ALU result, 01 ALUOut register, 10 jump target.
REQ-013 retire  out  1  one-cycle pulse in the final cycle of each legal instruction.
REQ-014 illegal  out  1  one-cycle pulse on an undecoded opcode.
REQ-015 state  out  4  current FSM state, for debug.

Function
REQ-016 Opcode map: R 0x00, J 0x02, BEQ 0x04, BNE 0x05, ADDI 0x08, SLTI 0x0A, ANDI 0x0C, ORI 0x0D, SUBI 0x0E, LUI 0x0F, LW 0x23, SW 0x2B.
REQ-017 States: FETCH 0, DECODE 1, MEMADDR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC_R 6, R_WB 7, EXEC_I 8, I_WB 9, BRANCH 10, JUMP 11; codes 12-15 go to FETCH on the next edge with all enables 0.
REQ-018 opcode is captured into an internal register in DECODE; all later states use the captured value.
REQ-019 FETCH: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=010, PCSource=00; PCWrite=IRWrite=mem_ready; the FSM holds until mem_ready=1, then goes to DECODE.
REQ-020 DECODE: ALUSrcA=00, ALUSrcB=11, ALUOp=010. Next state: LW/SW to MEMADDR, R to EXEC_R, I-type to EXEC_I, BEQ/BNE to BRANCH, J to JUMP. Any other opcode: illegal=1 and next state FETCH.
REQ-021 MEMADDR: ALUSrcA=01, ALUSrcB=10, ext_mode=00, ALUOp=010; LW goes to MEMRD, SW goes to MEMWR.
REQ-022 MEMRD: MemRead=1, IorD=1; the FSM holds until mem_ready, then goes to MEMWB. MEMWB: RegWrite=1, RegDst=0, MemtoReg=1, retire=1, next state FETCH.
REQ-023 MEMWR: MemWrite=1, IorD=1; the FSM holds until mem_ready. retire=1 in the mem_ready cycle; next state FETCH.
REQ-024 EXEC_R: ALUSrcA=01, ALUSrcB=00, ALUOp=000. R_WB: RegWrite=1, RegDst=1, MemtoReg=0, retire=1.
REQ-025 EXEC_I: ALUSrcB=10 and ALUOp per REQ-006. ext_mode is 01 for ANDI/ORI, 10 for LUI, 00 otherwise. ALUSrcA is 10 for LUI, 01 otherwise. I_WB: RegWrite=1, RegDst=0, MemtoReg=0, retire=1.
REQ-026 BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=001, PCSource=01; PCWrite=(BEQ&zero)|(BNE&~zero); retire=1.
REQ-027 JUMP: PCSource=10, PCWrite=1, retire=1.
REQ-028 Latency with mem_ready already high: R/I/SW 4 cycles, LW 5, BEQ/BNE/J 3. Each low mem_ready cycle in FETCH, MEMRD or MEMWR adds one cycle.
REQ-029 Any output not listed for a state is 0. Outputs are decoded combinationally from the state, the captured opcode, mem_ready and zero.
REQ-030 No two write enables among PCWrite, MemWrite and RegWrite are asserted in the same cycle except PCWrite with IRWrite in FETCH.

Reset
REQ-031 While rst_n=0, state=FETCH (0) and PCWrite, IRWrite, MemRead, MemWrite, RegWrite, retire and illegal are 0, independent of clk.
REQ-032 Reset asserted mid-instruction aborts it immediately with no further writes. After release, the FSM starts in FETCH on the first rising edge.

Verification
REQ-033 ADDI (0x08), mem_ready=1 throughout -> states 0,1,8,9. ALUOp=011 in EXEC_I, RegWrite=1 and retire=1 only in cycle 4.
REQ-034 LW (0x23), mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4. Total 7 cycles, MemtoReg=1 in MEMWB.
REQ-035 BEQ (0x04) with zero=1 -> PCWrite=1 in BRANCH. BNE (0x05) with zero=1 -> PCWrite=0. Both assert ALUOp=001 and retire once.
REQ-036 Opcode 0x3F -> illegal=1 in DECODE, next state FETCH, retire never asserted, no write enables.
REQ-037 rst_n dropped during MEMWR -> MemWrite=0 within the same cycle, without a clock edge. After release, state=0.
REQ-038 Back-to-back R (0x00), SW (0x2B), J (0x02) -> ALUOp 000 in EXEC_R, 010 in MEMADDR. retire pulses at cycles 4, 8 and 11.
